// File: rtl/calc_seq_pkg.sv
// Shared definitions for the calculator sequencer: FSM state encodings
// and LED mux select codes.
package calc_seq_pkg;

    typedef enum logic [3:0] {
        IDLE1   = 4'd0,
        LOAD1   = 4'd1,
        IDLE2   = 4'd2,
        LOAD2   = 4'd3,
        SHOW_MS = 4'd4,
        START   = 4'd5,
        WAIT    = 4'd6,
        DONE    = 4'd7,
        ERROR   = 4'd8
    } state_t;

    localparam logic [1:0] LED_DIN    = 2'b00;
    localparam logic [1:0] LED_MS     = 2'b01;
    localparam logic [1:0] LED_RESULT = 2'b10;
    localparam logic [1:0] LED_ERR    = 2'b11;

endpackage

// File: rtl/calc_sequencer_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// registered single-cycle pulse on each debounced rising edge.
module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic CLK,
    input  logic clear,
    input  logic raw,
    output logic pulse
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          db_level;
    logic          db_level_prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or posedge clear) begin
        if (clear) begin
            s1            <= 1'b0;
            s2            <= 1'b0;
            db_level      <= 1'b0;
            db_level_prev <= 1'b0;
            cnt           <= '0;
            pulse         <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // Level flips only after DB_CYCLES consecutive disagreeing samples.
            if (s2 != db_level) begin
                if (cnt == CNT_LAST) begin
                    db_level <= ~db_level;
                    cnt      <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
            db_level_prev <= db_level;
            pulse         <= db_level & ~db_level_prev;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator controller: sequences two operand loads, launches the ALU with
// a latched opcode, guards it with a timeout and drives display status.
module calc_sequencer
    import calc_seq_pkg::*;
#(
    parameter int DB_CYCLES = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic       CLK,
    input  logic       clear,
    input  logic       next_btn,
    input  logic [2:0] MS,
    input  logic       alu_done,
    input  logic       alu_err,
    output logic       WE,
    output logic       W1,
    output logic [3:0] MS_out,
    output logic       alu_start,
    output logic [1:0] LEDsel,
    output logic       Done_out,
    output logic       err_out,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic          next_pulse;
    logic [2:0]    ms_reg;
    logic [TW-1:0] tcount;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_debounce (
        .CLK  (CLK),
        .clear(clear),
        .raw  (next_btn),
        .pulse(next_pulse)
    );

    always_ff @(posedge CLK or posedge clear) begin
        if (clear) begin
            state <= IDLE1;
        end else begin
            state <= state_next;
        end
    end

    // Opcode is captured on the edge that enters START so it is already
    // valid while alu_start is high; later switch changes are ignored.
    always_ff @(posedge CLK or posedge clear) begin
        if (clear) begin
            ms_reg <= 3'b000;
            tcount <= '0;
        end else begin
            if (state == SHOW_MS && next_pulse) begin
                ms_reg <= MS;
            end
            if (state == WAIT) begin
                tcount <= tcount + TW'(1);
            end else begin
                tcount <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE1:   if (next_pulse) state_next = LOAD1;
            LOAD1:   state_next = IDLE2;
            IDLE2:   if (next_pulse) state_next = LOAD2;
            LOAD2:   state_next = SHOW_MS;
            SHOW_MS: if (next_pulse) state_next = START;
            START:   state_next = WAIT;
            WAIT: begin
                // A completion in the final timeout cycle still counts.
                if (alu_done) begin
                    state_next = alu_err ? ERROR : DONE;
                end else if (tcount == T_LAST) begin
                    state_next = ERROR;
                end
            end
            DONE:    if (next_pulse) state_next = IDLE1;
            ERROR:   if (next_pulse) state_next = IDLE1;
            default: state_next = IDLE1;
        endcase
    end

    always_comb begin
        WE        = 1'b0;
        W1        = 1'b0;
        MS_out    = 4'b0000;
        alu_start = 1'b0;
        LEDsel    = LED_DIN;
        Done_out  = 1'b0;
        err_out   = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE1: ;
            LOAD1: WE = 1'b1;
            IDLE2: W1 = 1'b1;
            LOAD2: begin
                WE     = 1'b1;
                W1     = 1'b1;
                LEDsel = LED_MS;
            end
            SHOW_MS: begin
                W1     = 1'b1;
                LEDsel = LED_MS;
                MS_out = {1'b0, MS};
            end
            START: begin
                W1        = 1'b1;
                LEDsel    = LED_MS;
                MS_out    = {1'b0, ms_reg};
                alu_start = 1'b1;
                busy      = 1'b1;
            end
            WAIT: begin
                W1     = 1'b1;
                LEDsel = LED_MS;
                MS_out = {1'b0, ms_reg};
                busy   = 1'b1;
            end
            DONE: begin
                W1       = 1'b1;
                LEDsel   = LED_RESULT;
                MS_out   = {1'b0, ms_reg};
                Done_out = 1'b1;
            end
            ERROR: begin
                W1      = 1'b1;
                LEDsel  = LED_ERR;
                MS_out  = {1'b0, ms_reg};
                err_out = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
